// File: rtl/iod_train_pkg.sv
// Shared definitions for the IOD delay-line eye trainer.
//   - train_state_e : 4-bit FSM state encoding (also exported on dbg_state)
//   - FAIL_*        : fail_code values reported on the fail_code output
//   - DEF_*_CYCLES  : default settle / sample window lengths
//   - TMR_W         : width of the shared settle/sample down-counter
package iod_train_pkg;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_LOAD     = 4'd1,
    ST_SETTLE   = 4'd2,
    ST_CLEAR    = 4'd3,
    ST_SAMPLE   = 4'd4,
    ST_EVAL     = 4'd5,
    ST_STEP_UP  = 4'd6,
    ST_CHECK    = 4'd7,
    ST_CTR_STEP = 4'd8,
    ST_DONE     = 4'd9,
    ST_FAIL     = 4'd10
  } train_state_e;

  localparam logic [1:0] FAIL_NONE    = 2'b00;
  localparam logic [1:0] FAIL_NO_PASS = 2'b01;
  localparam logic [1:0] FAIL_NARROW  = 2'b10;
  localparam logic [1:0] FAIL_OOR     = 2'b11;

  localparam int DEF_SETTLE_CYCLES = 8;
  localparam int DEF_SAMPLE_CYCLES = 16;
  localparam int TMR_W             = 8;

endpackage

// File: rtl/iod_pulse_timer.sv
// Loadable down-counter shared by the settle and sample windows.
// Ports:
//   clk_i, rst_ni  : clock, asynchronous active-low reset
//   load_i         : (re)start the window with load_val_i cycles
//   load_val_i     : window length in cycles (must be >= 1)
//   expired_o      : high for exactly one cycle, the last cycle of the window
module iod_pulse_timer
  import iod_train_pkg::*;
#(
  parameter int CNT_W = TMR_W
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             expired_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: reload, otherwise count down and park at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != CNT_W'(0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= CNT_W'(0);
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // A window of N cycles ends in the cycle the counter shows 1.
  assign expired_o = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/iod_dly_eye_trainer.sv
// Fabric-side delay-line eye trainer for one DDR3 PF_IOD lane (FAB_CLK domain).
// Sweeps the tap delay up from 0, finds the passing eye [L..R], steps back
// down to the eye centre and reports it on final_tap.
// Ports:
//   FAB_CLK, ARST_N            : clock, asynchronous active-low reset
//   start                      : one-cycle training request (ignored while busy)
//   busy / done / fail         : status; done and fail are sticky until next start
//   fail_code                  : 01 no pass, 10 eye too narrow, 11 out of range
//   final_tap                  : centre tap, valid while done=1
//   DELAY_LINE_LOAD/MOVE       : one-cycle pulses to the IOD delay line
//   DELAY_LINE_DIRECTION       : 1 = increment, 0 = decrement
//   EYE_MONITOR_CLEAR_FLAGS    : one-cycle pulse clearing the eye flags
//   EYE_MONITOR_EARLY/LATE     : eye monitor flags from the IOD
//   DELAY_LINE_OUT_OF_RANGE    : end-of-range flag from the IOD
// Optional build macro IOD_DLY_TRAIN_DEBUG_EN adds dbg_left, dbg_right and
// dbg_state outputs (registered L, R and FSM state).
module iod_dly_eye_trainer
  import iod_train_pkg::*;
#(
  parameter int TAP_W         = 8,
  parameter int MAX_TAP       = 127,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int SAMPLE_CYCLES = DEF_SAMPLE_CYCLES,
  parameter int MIN_EYE_TAPS  = 4
) (
  input  logic             FAB_CLK,
  input  logic             ARST_N,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             fail,
  output logic [1:0]       fail_code,
  output logic [TAP_W-1:0] final_tap,
  output logic             DELAY_LINE_LOAD,
  output logic             DELAY_LINE_MOVE,
  output logic             DELAY_LINE_DIRECTION,
  output logic             EYE_MONITOR_CLEAR_FLAGS,
  input  logic             EYE_MONITOR_EARLY,
  input  logic             EYE_MONITOR_LATE,
`ifdef IOD_DLY_TRAIN_DEBUG_EN
  input  logic             DELAY_LINE_OUT_OF_RANGE,
  output logic [TAP_W-1:0] dbg_left,
  output logic [TAP_W-1:0] dbg_right,
  output logic [3:0]       dbg_state
`else
  input  logic             DELAY_LINE_OUT_OF_RANGE
`endif
);

  localparam logic [TAP_W-1:0] MAX_TAP_C  = TAP_W'(MAX_TAP);
  // R-L+1 < MIN_EYE_TAPS is the same test as R-L < MIN_EYE_TAPS-1.
  localparam logic [TAP_W-1:0] MIN_SPAN_C = TAP_W'(MIN_EYE_TAPS - 1);
  localparam logic [TMR_W-1:0] SETTLE_C   = TMR_W'(SETTLE_CYCLES);
  localparam logic [TMR_W-1:0] SAMPLE_C   = TMR_W'(SAMPLE_CYCLES);

  train_state_e     state_q, state_d;
  logic [TAP_W-1:0] tap_q, tap_d;
  logic [TAP_W-1:0] left_q, left_d;
  logic [TAP_W-1:0] right_q, right_d;
  logic [TAP_W-1:0] centre_q, centre_d;
  logic             found_left_q, found_left_d;
  logic             centring_q, centring_d;
  logic             bad_q, bad_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             fail_q, fail_d;
  logic [1:0]       fail_code_q, fail_code_d;
  logic [TAP_W-1:0] final_tap_q, final_tap_d;
  logic             load_q, load_d;
  logic             move_q, move_d;
  logic             dir_q, dir_d;
  logic             clr_q, clr_d;

  logic [TAP_W-1:0] span_s;
  logic             found_nxt_s;
  logic             tmr_load_s;
  logic [TMR_W-1:0] tmr_val_s;
  logic             tmr_expired_s;

  iod_pulse_timer #(
    .CNT_W (TMR_W)
  ) u_timer (
    .clk_i      (FAB_CLK),
    .rst_ni     (ARST_N),
    .load_i     (tmr_load_s),
    .load_val_i (tmr_val_s),
    .expired_o  (tmr_expired_s)
  );

  // Next-state, datapath and registered-output next values.
  always_comb begin
    state_d      = state_q;
    tap_d        = tap_q;
    left_d       = left_q;
    right_d      = right_q;
    centre_d     = centre_q;
    found_left_d = found_left_q;
    centring_d   = centring_q;
    bad_d        = bad_q;
    busy_d       = busy_q;
    done_d       = done_q;
    fail_d       = fail_q;
    fail_code_d  = fail_code_q;
    final_tap_d  = final_tap_q;
    dir_d        = dir_q;
    span_s       = right_q - left_q;
    found_nxt_s  = found_left_q | ~bad_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          done_d      = 1'b0;
          fail_d      = 1'b0;
          fail_code_d = FAIL_NONE;
          final_tap_d = TAP_W'(0);
          busy_d      = 1'b1;
          dir_d       = 1'b1;  // sweep direction is up; set well ahead of the first MOVE
          state_d     = ST_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        tap_d        = TAP_W'(0);
        left_d       = TAP_W'(0);
        right_d      = TAP_W'(0);
        centre_d     = TAP_W'(0);
        found_left_d = 1'b0;
        centring_d   = 1'b0;
        state_d      = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (tmr_expired_s) begin
          state_d = centring_q ? ST_CTR_STEP : ST_CLEAR;
        end else begin
          state_d = ST_SETTLE;
        end
      end
      ST_CLEAR: begin
        bad_d   = 1'b0;
        state_d = ST_SAMPLE;
      end
      ST_SAMPLE: begin
        bad_d = bad_q | EYE_MONITOR_EARLY | EYE_MONITOR_LATE;
        if (tmr_expired_s) begin
          state_d = ST_EVAL;
        end else begin
          state_d = ST_SAMPLE;
        end
      end
      ST_EVAL: begin
        if (bad_q && found_left_q) begin
          right_d = tap_q - TAP_W'(1);  // tap > L here, so no underflow
          dir_d   = 1'b0;               // centring goes down; set before CTR_STEP
          state_d = ST_CHECK;
        end else begin
          if (!bad_q && !found_left_q) begin
            left_d       = tap_q;
            found_left_d = 1'b1;
          end else begin
            found_left_d = found_left_q;
          end
          if (tap_q == MAX_TAP_C) begin
            if (found_nxt_s) begin
              right_d = tap_q;
              dir_d   = 1'b0;
              state_d = ST_CHECK;
            end else begin
              fail_d      = 1'b1;
              fail_code_d = FAIL_NO_PASS;
              busy_d      = 1'b0;
              final_tap_d = TAP_W'(0);
              state_d     = ST_FAIL;
            end
          end else begin
            state_d = ST_STEP_UP;
          end
        end
      end
      ST_STEP_UP: begin
        // OUT_OF_RANGE seen alongside the MOVE means the IOD did not step.
        if (DELAY_LINE_OUT_OF_RANGE) begin
          if (found_left_q) begin
            right_d = tap_q;
            dir_d   = 1'b0;
            state_d = ST_CHECK;
          end else begin
            fail_d      = 1'b1;
            fail_code_d = FAIL_OOR;
            busy_d      = 1'b0;
            final_tap_d = TAP_W'(0);
            state_d     = ST_FAIL;
          end
        end else begin
          tap_d   = (tap_q == MAX_TAP_C) ? tap_q : tap_q + TAP_W'(1);
          state_d = ST_SETTLE;
        end
      end
      ST_CHECK: begin
        if (span_s < MIN_SPAN_C) begin
          fail_d      = 1'b1;
          fail_code_d = FAIL_NARROW;
          busy_d      = 1'b0;
          final_tap_d = TAP_W'(0);
          state_d     = ST_FAIL;
        end else begin
          centre_d   = left_q + (span_s >> 1);
          centring_d = 1'b1;
          state_d    = ST_CTR_STEP;
        end
      end
      ST_CTR_STEP: begin
        if (tap_q > centre_q) begin
          tap_d   = tap_q - TAP_W'(1);
          state_d = ST_SETTLE;
        end else begin
          done_d      = 1'b1;
          busy_d      = 1'b0;
          final_tap_d = tap_q;
          state_d     = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      ST_FAIL: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Pulses are decoded from the next state so they line up with it.
    load_d = (state_d == ST_LOAD);
    clr_d  = (state_d == ST_CLEAR);
    move_d = (state_d == ST_STEP_UP) ||
             ((state_d == ST_CTR_STEP) && (tap_d > centre_d));

    tmr_load_s = (state_d != state_q) &&
                 ((state_d == ST_SETTLE) || (state_d == ST_SAMPLE));
    tmr_val_s  = (state_d == ST_SAMPLE) ? SAMPLE_C : SETTLE_C;
  end

  // State, datapath and output registers.
  always_ff @(posedge FAB_CLK or negedge ARST_N) begin
    if (!ARST_N) begin
      state_q      <= ST_IDLE;
      tap_q        <= TAP_W'(0);
      left_q       <= TAP_W'(0);
      right_q      <= TAP_W'(0);
      centre_q     <= TAP_W'(0);
      found_left_q <= 1'b0;
      centring_q   <= 1'b0;
      bad_q        <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      fail_q       <= 1'b0;
      fail_code_q  <= FAIL_NONE;
      final_tap_q  <= TAP_W'(0);
      load_q       <= 1'b0;
      move_q       <= 1'b0;
      dir_q        <= 1'b0;
      clr_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      tap_q        <= tap_d;
      left_q       <= left_d;
      right_q      <= right_d;
      centre_q     <= centre_d;
      found_left_q <= found_left_d;
      centring_q   <= centring_d;
      bad_q        <= bad_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      fail_q       <= fail_d;
      fail_code_q  <= fail_code_d;
      final_tap_q  <= final_tap_d;
      load_q       <= load_d;
      move_q       <= move_d;
      dir_q        <= dir_d;
      clr_q        <= clr_d;
    end
  end

  assign busy                    = busy_q;
  assign done                    = done_q;
  assign fail                    = fail_q;
  assign fail_code               = fail_code_q;
  assign final_tap               = final_tap_q;
  assign DELAY_LINE_LOAD         = load_q;
  assign DELAY_LINE_MOVE         = move_q;
  assign DELAY_LINE_DIRECTION    = dir_q;
  assign EYE_MONITOR_CLEAR_FLAGS = clr_q;

`ifdef IOD_DLY_TRAIN_DEBUG_EN
  assign dbg_left  = left_q;
  assign dbg_right = right_q;
  assign dbg_state = state_q;
`endif

endmodule

// File: tb/tb_iod_dly_eye_trainer.sv
// Self-checking bench for iod_dly_eye_trainer with a behavioural IOD lane model.
module tb_iod_dly_eye_trainer;

  logic       FAB_CLK = 1'b0;
  logic       ARST_N  = 1'b0;
  logic       start   = 1'b0;
  logic       busy, done, fail;
  logic [1:0] fail_code;
  logic [7:0] final_tap;
  logic       DELAY_LINE_LOAD, DELAY_LINE_MOVE, DELAY_LINE_DIRECTION;
  logic       EYE_MONITOR_CLEAR_FLAGS;
  logic       EYE_MONITOR_EARLY, EYE_MONITOR_LATE, DELAY_LINE_OUT_OF_RANGE;

  // IOD lane model state
  logic [7:0] model_tap = 8'd0;
  int pass_lo = 0;
  int pass_hi = -1;
  int oor_tap = 1000;

  int load_total = 0;
  int dec_total  = 0;
  int proto_viol = 0;
  logic prev_dir = 1'b0, prev_load = 1'b0, prev_move = 1'b0, prev_clr = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string      name;
    logic       exp_done;
    logic [1:0] exp_code;
    logic [7:0] exp_tap;
    int         exp_dec;
  } exp_t;
  exp_t sb_q[$];

  iod_dly_eye_trainer dut (
    .FAB_CLK                 (FAB_CLK),
    .ARST_N                  (ARST_N),
    .start                   (start),
    .busy                    (busy),
    .done                    (done),
    .fail                    (fail),
    .fail_code               (fail_code),
    .final_tap               (final_tap),
    .DELAY_LINE_LOAD         (DELAY_LINE_LOAD),
    .DELAY_LINE_MOVE         (DELAY_LINE_MOVE),
    .DELAY_LINE_DIRECTION    (DELAY_LINE_DIRECTION),
    .EYE_MONITOR_CLEAR_FLAGS (EYE_MONITOR_CLEAR_FLAGS),
    .EYE_MONITOR_EARLY       (EYE_MONITOR_EARLY),
    .EYE_MONITOR_LATE        (EYE_MONITOR_LATE),
    .DELAY_LINE_OUT_OF_RANGE (DELAY_LINE_OUT_OF_RANGE)
  );

  always #5 FAB_CLK = ~FAB_CLK;

  // Eye: early below pass_lo, late above pass_hi; end of range on the up-move from oor_tap.
  assign EYE_MONITOR_EARLY       = (int'(model_tap) < pass_lo);
  assign EYE_MONITOR_LATE        = (int'(model_tap) > pass_hi);
  assign DELAY_LINE_OUT_OF_RANGE = DELAY_LINE_MOVE && DELAY_LINE_DIRECTION &&
                                   (int'(model_tap) == oor_tap);

  // Delay-line model plus pulse/direction protocol monitor.
  always @(posedge FAB_CLK) begin
    if (DELAY_LINE_LOAD)
      model_tap <= 8'd0;
    else if (DELAY_LINE_MOVE && !DELAY_LINE_OUT_OF_RANGE)
      model_tap <= DELAY_LINE_DIRECTION ? model_tap + 8'd1 : model_tap - 8'd1;
    if (DELAY_LINE_LOAD) load_total <= load_total + 1;
    if (DELAY_LINE_MOVE && !DELAY_LINE_DIRECTION) dec_total <= dec_total + 1;
    if ((DELAY_LINE_MOVE && (DELAY_LINE_DIRECTION != prev_dir)) ||
        (DELAY_LINE_LOAD && prev_load) || (DELAY_LINE_MOVE && prev_move) ||
        (EYE_MONITOR_CLEAR_FLAGS && prev_clr))
      proto_viol <= proto_viol + 1;
    prev_dir  <= DELAY_LINE_DIRECTION;
    prev_load <= DELAY_LINE_LOAD;
    prev_move <= DELAY_LINE_MOVE;
    prev_clr  <= EYE_MONITOR_CLEAR_FLAGS;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] all_outs();
    return {17'd0, busy, done, fail, fail_code, final_tap, DELAY_LINE_LOAD,
            DELAY_LINE_MOVE, DELAY_LINE_DIRECTION, EYE_MONITOR_CLEAR_FLAGS};
  endfunction

  task automatic set_eye(input int lo, input int hi, input int oor);
    pass_lo = lo;
    pass_hi = hi;
    oor_tap = oor;
  endtask

  // Pulse start at a negedge and check the first cycle of the run.
  task automatic pulse_start(input string name);
    start = 1'b1;
    @(negedge FAB_CLK);
    start = 1'b0;
    check_eq({name, "_busy_set"}, 32'(busy), 32'd1);
    check_eq({name, "_done_clr"}, 32'(done), 32'd0);
    check_eq({name, "_fail_clr"}, 32'(fail), 32'd0);
    check_eq({name, "_load_first"}, 32'(DELAY_LINE_LOAD), 32'd1);
  endtask

  // Drive one training run; expectation goes into the scoreboard, result is popped on completion.
  task automatic run_training(input string name, input logic exp_done, input logic [1:0] exp_code,
                              input logic [7:0] exp_tap, input int exp_dec, input bit extra_starts);
    int   load0, dec0, c;
    exp_t e;
    sb_q.push_back('{name, exp_done, exp_code, exp_tap, exp_dec});
    @(negedge FAB_CLK);
    load0 = load_total;
    dec0  = dec_total;
    pulse_start(name);
    c = 0;
    while (!(done || fail) && c < 20000) begin
      start = extra_starts && (c == 50 || c == 400);
      @(negedge FAB_CLK);
      c++;
    end
    start = 1'b0;
    e = sb_q.pop_front();
    if (!(done || fail)) begin
      check_eq({e.name, "_timeout"}, 32'(c), 32'd0);
    end else begin
      check_eq({e.name, "_done"}, 32'(done), 32'(e.exp_done));
      check_eq({e.name, "_fail"}, 32'(fail), 32'(!e.exp_done));
      check_eq({e.name, "_code"}, 32'(fail_code), 32'(e.exp_code));
      check_eq({e.name, "_final_tap"}, 32'(final_tap), 32'(e.exp_tap));
      check_eq({e.name, "_busy_low"}, 32'(busy), 32'd0);
      check_eq({e.name, "_loads"}, 32'(load_total - load0), 32'd1);
      check_eq({e.name, "_dec_moves"}, 32'(dec_total - dec0), 32'(e.exp_dec));
      repeat (3) @(negedge FAB_CLK);
      check_eq({e.name, "_sticky"}, 32'({done, fail}), 32'({e.exp_done, !e.exp_done}));
    end
  endtask

  initial begin
    int c;
    repeat (3) @(negedge FAB_CLK);
    check_eq("reset_outs", all_outs(), 32'd0);
    ARST_N = 1'b1;
    repeat (2) @(negedge FAB_CLK);
    check_eq("idle_outs", all_outs(), 32'd0);

    // Eye 20..59: R=59 found at 60, centre 39, 21 decrements.
    set_eye(20, 59, 1000);
    run_training("eye20_59", 1'b1, 2'b00, 8'd39, 21, 1'b0);
    // Restart after done, with extra start pulses while busy.
    run_training("restart_busy", 1'b1, 2'b00, 8'd39, 21, 1'b1);
    // Never passing through tap 127.
    set_eye(1000, -1, 1000);
    run_training("no_pass", 1'b0, 2'b01, 8'd0, 0, 1'b0);
    // Pass everywhere, end of range on the move from tap 100.
    set_eye(0, 255, 100);
    run_training("oor100", 1'b1, 2'b00, 8'd50, 50, 1'b0);
    // Only 3 passing taps.
    set_eye(10, 12, 1000);
    run_training("narrow", 1'b0, 2'b10, 8'd0, 0, 1'b0);
    // End of range before any pass.
    set_eye(1000, -1, 5);
    run_training("oor_nopass", 1'b0, 2'b11, 8'd0, 0, 1'b0);
    // Wide eye ending at MAX_TAP: L=100, R=127, centre 113.
    set_eye(100, 255, 1000);
    run_training("max_edge", 1'b1, 2'b00, 8'd113, 14, 1'b0);

    // Reset during the sample window at tap 30.
    set_eye(20, 59, 1000);
    pulse_start("abort");
    c = 0;
    while (!(model_tap == 8'd30 && EYE_MONITOR_CLEAR_FLAGS) && c < 5000) begin
      @(negedge FAB_CLK);
      c++;
    end
    check_eq("abort_reach_tap30", 32'(model_tap), 32'd30);
    repeat (3) @(negedge FAB_CLK);
    #2 ARST_N = 1'b0;
    #1 check_eq("abort_outs_in_reset", all_outs(), 32'd0);
    repeat (2) @(negedge FAB_CLK);
    ARST_N = 1'b1;
    repeat (2) @(negedge FAB_CLK);
    check_eq("abort_outs_after", all_outs(), 32'd0);
    run_training("after_reset", 1'b1, 2'b00, 8'd39, 21, 1'b0);

    check_eq("protocol_viol", 32'(proto_viol), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/iod_dly_eye_trainer.md
Name: iod_dly_eye_trainer

Overview:
Fabric-side delay-line training controller that sits directly beside one DDR3 PF_IOD lane, on FAB_CLK. It drives the lane's DELAY_LINE_LOAD/MOVE/DIRECTION and EYE_MONITOR_CLEAR_FLAGS inputs, and consumes the lane's EYE_MONITOR_EARLY/LATE and DELAY_LINE_OUT_OF_RANGE outputs. It sweeps the tap delay upward, finds the passing eye (left and right edge), then steps back to the eye centre and reports the final tap.

Parameters:
TAP_W, 8, tap counter width; matches the 8-bit IOD delay value.
MAX_TAP, 127, highest tap swept before a forced stop.
SETTLE_CYCLES, 8, FAB_CLK cycles waited after any LOAD or MOVE pulse.
SAMPLE_CYCLES, 16, FAB_CLK cycles the eye flags are observed per tap.
MIN_EYE_TAPS, 4, minimum passing width (R-L+1) accepted.

Ports:
FAB_CLK  in  1  fabric clock, same clock as the IOD RX_CLK/TX_CLK
ARST_N  in  1  asynchronous active-low reset
start  in  1  one-cycle training request; ignored while busy
busy  out  1  high from the cycle after start until done or fail
done  out  1  sticky success flag; cleared by start or reset
fail  out  1  sticky failure flag; cleared by start or reset
fail_code  out  2  01 no passing tap, 10 eye too narrow, 11 out of range before any pass
final_tap  out  TAP_W  tap count at the centre; valid while done=1
DELAY_LINE_LOAD  out  1  one-cycle pulse that returns the delay to tap 0
DELAY_LINE_MOVE  out  1  one-cycle pulse that moves one tap
DELAY_LINE_DIRECTION  out  1  1 = increment, 0 = decrement
EYE_MONITOR_CLEAR_FLAGS  out  1  one-cycle pulse that clears the early/late flags
EYE_MONITOR_EARLY  in  1  early flag from the IOD
EYE_MONITOR_LATE  in  1  late flag from the IOD
DELAY_LINE_OUT_OF_RANGE  in  1  end-of-range flag from the IOD

Behaviour:
- Reset (async, ARST_N=0): all outputs 0, FSM=IDLE, tap=0, L=R=0, found_left=0. This holds even mid-operation.
- All outputs are registered. Every pulse output is exactly 1 cycle wide.
- DIRECTION is set one cycle before MOVE and held through the MOVE cycle.
- FSM states:
  - IDLE: on start, clear done/fail, set busy, go to LOAD.
  - LOAD: pulse DELAY_LINE_LOAD, set tap=0, go to SETTLE.
  - SETTLE: count SETTLE_CYCLES, then go to CLEAR (sweep) or CTR_STEP (centring).
  - CLEAR: pulse EYE_MONITOR_CLEAR_FLAGS, go to SAMPLE.
  - SAMPLE: OR-accumulate EARLY|LATE over SAMPLE_CYCLES into bad. The accumulation starts the cycle after CLEAR. Then go to EVAL.
  - EVAL (one cycle):
    - !bad and !found_left: L=tap, found_left=1.
    - bad and found_left: R=tap-1, go to CHECK.
    - Otherwise, if tap==MAX_TAP: R=tap if found_left (go to CHECK), else fail code 01.
    - Otherwise go to STEP_UP.
  - STEP_UP: DIRECTION=1, MOVE pulse, tap+1, go to SETTLE. If DELAY_LINE_OUT_OF_RANGE is seen with the MOVE: keep tap unchanged; R=tap if found_left (go to CHECK), else fail code 11.
  - CHECK: if R-L+1 < MIN_EYE_TAPS, fail code 10. Else centre = L+((R-L)>>1) (floor), go to CTR_STEP.
  - CTR_STEP: while tap > centre, DIRECTION=0, MOVE pulse, tap-1, SETTLE; when tap==centre go to DONE.
  - DONE: final_tap=tap, done=1, busy=0, return to IDLE.
  - FAIL: fail=1, fail_code set, busy=0, final_tap=0.
- Arithmetic: unsigned, TAP_W bits. Tap never wraps: the increment saturates at MAX_TAP, the decrement stops at centre (centre >= L >= 0).
- Simultaneous events: start in the same cycle as DONE/FAIL entry is ignored. A start pulse while busy is ignored. Flags asserted during SETTLE are ignored (they are cleared by CLEAR).

Optional Feature:
IOD_DLY_TRAIN_DEBUG_EN:
- Defined: adds outputs dbg_left (TAP_W), dbg_right (TAP_W) and dbg_state (4). These are registered L, R and FSM encoding, all 0 at reset.
- Undefined: these ports and registers are absent; the remaining behaviour is identical.

Decomposition:
- Shared package iod_train_pkg: FSM state enum (4-bit), fail_code localparams (FAIL_NONE/NO_PASS/NARROW/OOR), default SETTLE/SAMPLE constants.
- One natural sub-module: iod_pulse_timer, a loadable down-counter that serves both SETTLE and SAMPLE and raises `expired` for one cycle.

Test Plan:
- IOD model passes taps 20..59 (flags high elsewhere); start -> R=59 seen at tap 60, 21 decrement MOVE pulses, done=1, final_tap=39.
- Flags always high through tap 127 -> fail=1, fail_code=01, busy=0, final_tap=0.
- Pass from tap 0; OUT_OF_RANGE asserted on the move from tap 100 -> L=0, R=100, final_tap=50, done=1.
- Pass only at taps 10..12 -> width 3 < 4 -> fail=1, fail_code=10.
- ARST_N low for 2 cycles during SAMPLE at tap 30 -> all outputs 0 immediately; a new start then trains normally with LOAD issued first.
- start pulsed while busy -> no effect on LOAD count or result; start after done -> done clears next cycle, LOAD pulse, new training.
